// File: rtl/avs_ahb_lite_pkg.sv
// avs_ahb_lite_pkg: AHB-Lite encodings and the byteenable decode result shared by the bridge.
package avs_ahb_lite_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef struct packed {
    logic legal;
    logic [2:0] size;
    logic [1:0] off;
  } be_dec_t;
endpackage

// File: rtl/avs_ahb_lite_if.sv
// avs_ahb_lite_if: Avalon-MM and AHB-Lite bus bundles used by the bridge.
//   avs_ahb_lite_avs_if: Avalon command (address/read/write/byteenable/writedata) from the master,
//     waitrequest/readdata/readdatavalid/writeresponsevalid/response back to it.
//   avs_ahb_lite_ahb_if: AHB-Lite address/control/HWDATA from the master, HRDATA/HREADY/HRESP back.
interface avs_ahb_lite_avs_if #(parameter int AVS_AW = 16);
  logic [AVS_AW-1:0] avs_address;
  logic avs_read;
  logic avs_write;
  logic [3:0] avs_byteenable;
  logic [31:0] avs_writedata;
  logic avs_waitrequest;
  logic [31:0] avs_readdata;
  logic avs_readdatavalid;
  logic avs_writeresponsevalid;
  logic [1:0] avs_response;
  modport master (
    output avs_address, avs_read, avs_write, avs_byteenable, avs_writedata,
    input avs_waitrequest, avs_readdata, avs_readdatavalid, avs_writeresponsevalid, avs_response
  );
  modport slave (
    input avs_address, avs_read, avs_write, avs_byteenable, avs_writedata,
    output avs_waitrequest, avs_readdata, avs_readdatavalid, avs_writeresponsevalid, avs_response
  );
endinterface

interface avs_ahb_lite_ahb_if;
  logic [31:0] HADDR;
  logic [1:0] HTRANS;
  logic HWRITE;
  logic [2:0] HSIZE;
  logic [2:0] HBURST;
  logic [3:0] HPROT;
  logic HMASTLOCK;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic HREADY;
  logic HRESP;
  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    input HRDATA, HREADY, HRESP
  );
  modport slave (
    input HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/avs_ahb_be_decode.sv
// avs_ahb_be_decode: maps Avalon byteenable to {legal, HSIZE, byte offset}, combinational.
//   be  in  4  byte lanes
//   dec out    decode result; legal=0 for any pattern that is not a naturally aligned byte/half/word
module avs_ahb_be_decode
  import avs_ahb_lite_pkg::*;
(
  input logic [3:0] be,
  output be_dec_t dec
);
  always_comb begin
    dec = '{legal: 1'b1, size: HSIZE_BYTE, off: 2'd0};
    case (be)
      4'b0001: dec.off = 2'd0;
      4'b0010: dec.off = 2'd1;
      4'b0100: dec.off = 2'd2;
      4'b1000: dec.off = 2'd3;
      4'b0011: dec.size = HSIZE_HALF;
      4'b1100: dec = '{legal: 1'b1, size: HSIZE_HALF, off: 2'd2};
      4'b1111: dec.size = HSIZE_WORD;
      default: dec.legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/avs_ahb_lite.sv
// avs_ahb_lite: Avalon-MM slave to AHB-Lite master bridge, one SINGLE transfer in flight.
//   HCLK     in   clock shared by both buses
//   HRESETn  in   asynchronous active-low reset
//   avs      Avalon-MM slave side (command in, waitrequest and completion pulses out)
//   ahb      AHB-Lite master side (address/control/HWDATA out, HRDATA/HREADY/HRESP in)
module avs_ahb_lite
  import avs_ahb_lite_pkg::*;
#(
  parameter int AVS_AW = 16,
  parameter logic [31:0] HADDR_BASE = 32'h0000_0000,
  parameter int HDATA_WIDTH = 32
) (
  input logic HCLK,
  input logic HRESETn,
  avs_ahb_lite_avs_if.slave avs,
  avs_ahb_lite_ahb_if.master ahb
);
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;
  state_t state, state_nx;
  be_dec_t dec;
  logic cmd;
  logic write_q, err_q;
  logic [31:0] haddr_q;
  logic [2:0] hsize_q;
  logic [HDATA_WIDTH-1:0] wdata_q, rdata_q;
  assign cmd = avs.avs_read | avs.avs_write;
  avs_ahb_be_decode u_dec (.be(avs.avs_byteenable), .dec(dec));
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) state <= S_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    ahb.HTRANS = HTRANS_IDLE;
    avs.avs_readdatavalid = 1'b0;
    avs.avs_writeresponsevalid = 1'b0;
    avs.avs_response = RESP_OKAY;
    case (state)
      S_IDLE: state_nx = cmd ? (dec.legal ? S_ADDR : S_RESP) : S_IDLE;
      S_ADDR: begin
        ahb.HTRANS = HTRANS_NONSEQ;
        state_nx = ahb.HREADY ? S_DATA : S_ADDR;
      end
      S_DATA: state_nx = ahb.HREADY ? S_RESP : S_DATA;
      default: begin
        avs.avs_readdatavalid = ~write_q;
        avs.avs_writeresponsevalid = write_q;
        avs.avs_response = err_q ? RESP_SLVERR : RESP_OKAY;
        state_nx = S_IDLE;
      end
    endcase
  end
  // An illegal byteenable pre-loads the error flag; a legal transfer overwrites it with the
  // HRESP seen on its final data-phase cycle (earlier HRESP cycles are the first half of the
  // two-cycle AHB error response and are ignored).
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      haddr_q <= HADDR_BASE;
      hsize_q <= HSIZE_BYTE;
      write_q <= 1'b0;
      err_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state == S_IDLE && cmd) begin
        haddr_q <= HADDR_BASE | 32'({avs.avs_address, dec.off});
        hsize_q <= dec.size;
        write_q <= avs.avs_write;
        wdata_q <= avs.avs_writedata;
        err_q <= ~dec.legal;
        if (!dec.legal && !avs.avs_write) rdata_q <= '0;
      end
      if (state == S_DATA && ahb.HREADY) begin
        err_q <= ahb.HRESP;
        if (!write_q) rdata_q <= ahb.HRDATA;
      end
    end
  assign ahb.HADDR = haddr_q;
  assign ahb.HWRITE = write_q;
  assign ahb.HSIZE = hsize_q;
  assign ahb.HBURST = HBURST_SINGLE;
  assign ahb.HPROT = HPROT_DATA_PRIV;
  assign ahb.HMASTLOCK = 1'b0;
  assign ahb.HWDATA = wdata_q;
  assign avs.avs_readdata = rdata_q;
  assign avs.avs_waitrequest = (state != S_IDLE) | ~HRESETn;
endmodule

// File: tb/tb_avs_ahb_lite.sv
// tb_avs_ahb_lite: directed bench with a transaction-level model of the bridge and a per-cycle checker.
module tb_avs_ahb_lite;
  import avs_ahb_lite_pkg::*;
  localparam logic [31:0] BASE = 32'h1000_0000;
  logic HCLK = 1'b0;
  logic HRESETn = 1'b1;
  always #5 HCLK = ~HCLK;
  avs_ahb_lite_avs_if #(.AVS_AW(16)) avs();
  avs_ahb_lite_ahb_if ahb();
  avs_ahb_lite #(.AVS_AW(16), .HADDR_BASE(BASE), .HDATA_WIDTH(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .avs(avs), .ahb(ahb)
  );
  typedef struct {
    logic wr;
    logic legal;
    logic [31:0] addr;
    logic [2:0] size;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0] resp;
    int t0;
    int nonseq;
    logic addr_done;
    logic done;
  } txn_t;
  int n_chk = 0, n_fail = 0, cyc = 0;
  txn_t t;
  bit busy = 0, dphase = 0, err_cfg = 0;
  int aw = 0, dw = 0, acnt = 0, dcnt = 0, pulses = 0, last_lat = 0, last_nonseq = 0;
  logic [31:0] rd_cfg = '0, last_rdata = '0, last_haddr = '0, last_hwdata = '0;
  logic [1:0] last_resp = '0;
  logic last_wr = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Legal patterns are one lane, two adjacent lanes starting at an even lane, or all four.
  function automatic void model_be(input logic [3:0] be, output logic legal, output logic [2:0] size,
                                   output logic [1:0] off);
    int n = $countones(be);
    int lo = 0;
    while (lo < 4 && !be[lo]) lo++;
    legal = (n == 4) || (n == 1) || (n == 2 && lo % 2 == 0 && be[lo+1]);
    size = n == 1 ? HSIZE_BYTE : n == 2 ? HSIZE_HALF : HSIZE_WORD;
    off = 2'(lo);
  endfunction

  // Checker, AHB slave responder and model update, all evaluated mid-cycle.
  initial begin
    bit b0, exp_p, exp_ns, rdy;
    logic lg;
    logic [2:0] sz;
    logic [1:0] of;
    forever begin
      @(negedge HCLK);
      cyc++;
      if (!HRESETn) begin
        check("rst_waitrequest", avs.avs_waitrequest, 1);
        check("rst_htrans", ahb.HTRANS, HTRANS_IDLE);
        check("rst_readdatavalid", avs.avs_readdatavalid, 0);
        check("rst_writeresponsevalid", avs.avs_writeresponsevalid, 0);
        check("rst_response", avs.avs_response, 0);
        check("rst_readdata", avs.avs_readdata, 0);
        busy = 0; dphase = 0; acnt = 0; dcnt = 0; last_rdata = '0;
        ahb.HREADY = 1'b1; ahb.HRESP = 1'b0; ahb.HRDATA = '0;
      end else begin
        b0 = busy;
        exp_ns = busy && t.legal && !t.addr_done;
        exp_p = busy && (t.legal ? t.done : cyc == t.t0 + 1);
        check("hburst", ahb.HBURST, HBURST_SINGLE);
        check("hprot", ahb.HPROT, 4'b0011);
        check("hmastlock", ahb.HMASTLOCK, 0);
        check("waitrequest", avs.avs_waitrequest, busy);
        check("htrans", ahb.HTRANS, exp_ns ? HTRANS_NONSEQ : HTRANS_IDLE);
        if (exp_ns) begin
          check("haddr", ahb.HADDR, t.addr);
          check("hsize", ahb.HSIZE, t.size);
          check("hwrite", ahb.HWRITE, t.wr);
          last_haddr = ahb.HADDR;
          t.nonseq++;
        end
        check("readdatavalid", avs.avs_readdatavalid, exp_p && !t.wr);
        check("writeresponsevalid", avs.avs_writeresponsevalid, exp_p && t.wr);
        if (exp_p) begin
          check("response", avs.avs_response, t.resp);
          last_resp = avs.avs_response;
          last_wr = avs.avs_writeresponsevalid;
          last_lat = cyc - t.t0;
          last_nonseq = t.nonseq;
          pulses++;
          busy = 0;
          if (!t.wr) last_rdata = t.rdata;
        end
        check("readdata", avs.avs_readdata, last_rdata);
        if (dphase && t.wr) begin
          check("hwdata", ahb.HWDATA, t.wdata);
          last_hwdata = ahb.HWDATA;
        end
        if (dphase) begin
          rdy = dcnt >= dw;
          ahb.HREADY = rdy;
          ahb.HRESP = err_cfg && dcnt + 1 >= dw;
          ahb.HRDATA = rdy ? rd_cfg : 32'hBAD0_0000 | 32'(dcnt);
          dcnt++;
          if (rdy) begin dphase = 0; t.done = 1; end
        end else if (ahb.HTRANS == HTRANS_NONSEQ) begin
          rdy = acnt >= aw;
          ahb.HREADY = rdy;
          ahb.HRESP = 1'b0;
          acnt++;
          if (rdy) begin dphase = 1; dcnt = 0; acnt = 0; t.addr_done = 1; end
        end else begin
          ahb.HREADY = 1'b1;
          ahb.HRESP = 1'b0;
        end
        if (!b0 && (avs.avs_read || avs.avs_write)) begin
          model_be(avs.avs_byteenable, lg, sz, of);
          t.wr = avs.avs_write;
          t.legal = lg;
          t.size = sz;
          t.addr = BASE | {14'b0, avs.avs_address, of};
          t.wdata = avs.avs_writedata;
          t.rdata = lg ? rd_cfg : 32'h0;
          t.resp = (!lg || err_cfg) ? 2'b10 : 2'b00;
          t.t0 = cyc; t.nonseq = 0; t.addr_done = 0; t.done = 0;
          busy = 1; acnt = 0;
        end
      end
    end
  end

  task automatic cmd(input logic [15:0] a, input logic rd, input logic wr, input logic [3:0] be,
                     input logic [31:0] wd, input int a_w, input int d_w, input logic [31:0] rdat,
                     input bit er);
    aw = a_w; dw = d_w; rd_cfg = rdat; err_cfg = er;
    avs.avs_address = a; avs.avs_byteenable = be; avs.avs_writedata = wd;
    avs.avs_read = rd; avs.avs_write = wr;
    @(posedge HCLK); #2;
    avs.avs_read = 1'b0; avs.avs_write = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (busy && n < 60) begin @(posedge HCLK); n++; end
    #2;
    check({name, "_completion_timeout"}, busy, 0);
  endtask

  initial begin
    int n, np;
    avs.avs_address = '0; avs.avs_read = 1'b0; avs.avs_write = 1'b0;
    avs.avs_byteenable = '0; avs.avs_writedata = '0;
    #1 HRESETn = 1'b0;
    repeat (3) @(posedge HCLK);
    #2 HRESETn = 1'b1;
    @(posedge HCLK); #2;
    cmd(16'h0010, 1, 0, 4'b1111, 32'h0, 0, 0, 32'hCAFE_BABE, 0);
    wait_done("word_read");
    check("word_read_latency", last_lat, 3);
    check("word_read_haddr", last_haddr, 32'h1000_0040);
    check("word_read_data", avs.avs_readdata, 32'hCAFE_BABE);
    check("word_read_resp", last_resp, 2'b00);
    check("word_read_nonseq", last_nonseq, 1);
    cmd(16'h0021, 0, 1, 4'b0100, 32'h00AB_0000, 0, 0, 32'h0, 0);
    wait_done("byte_write");
    check("byte_write_latency", last_lat, 3);
    check("byte_write_haddr", last_haddr, 32'h1000_0086);
    check("byte_write_hwdata", last_hwdata, 32'h00AB_0000);
    check("byte_write_resp", last_resp, 2'b00);
    check("byte_write_rdata_hold", avs.avs_readdata, 32'hCAFE_BABE);
    cmd(16'h0003, 1, 0, 4'b1100, 32'h0, 2, 3, 32'h1234_5678, 0);
    wait_done("wait_read");
    check("wait_read_latency", last_lat, 8);
    check("wait_read_nonseq", last_nonseq, 3);
    check("wait_read_haddr", last_haddr, 32'h1000_000E);
    check("wait_read_data", avs.avs_readdata, 32'h1234_5678);
    cmd(16'h0005, 1, 0, 4'b0011, 32'h0, 0, 1, 32'h0BAD_F00D, 1);
    wait_done("err_read");
    check("err_read_resp", last_resp, 2'b10);
    check("err_read_latency", last_lat, 4);
    check("err_read_data", avs.avs_readdata, 32'h0BAD_F00D);
    cmd(16'h0006, 0, 1, 4'b0101, 32'hFFFF_FFFF, 0, 0, 32'h0, 0);
    wait_done("illegal_write");
    check("illegal_write_resp", last_resp, 2'b10);
    check("illegal_write_latency", last_lat, 1);
    check("illegal_write_nonseq", last_nonseq, 0);
    check("illegal_write_kind", last_wr, 1);
    cmd(16'h0006, 1, 0, 4'b0000, 32'h0, 0, 0, 32'h7777_7777, 0);
    wait_done("illegal_read");
    check("illegal_read_data", avs.avs_readdata, 32'h0);
    check("illegal_read_resp", last_resp, 2'b10);
    cmd(16'h0007, 1, 1, 4'b0010, 32'h0000_5500, 0, 0, 32'h0, 0);
    wait_done("rw_both");
    check("rw_both_kind", last_wr, 1);
    check("rw_both_haddr", last_haddr, 32'h1000_001D);
    cmd(16'hFFFF, 1, 0, 4'b1000, 32'h0, 0, 0, 32'hA5A5_A5A5, 0);
    wait_done("top_byte_read");
    check("top_byte_read_haddr", last_haddr, 32'h1003_FFFF);
    check("top_byte_read_data", avs.avs_readdata, 32'hA5A5_A5A5);
    np = pulses;
    cmd(16'h0009, 0, 1, 4'b1111, 32'h5A5A_5A5A, 0, 5, 32'h0, 0);
    n = 0;
    while (!dphase && n < 20) begin @(posedge HCLK); n++; end
    check("reach_data_phase", dphase, 1);
    @(posedge HCLK); #2 HRESETn = 1'b0;
    repeat (2) @(posedge HCLK);
    #2 HRESETn = 1'b1;
    repeat (3) @(posedge HCLK);
    #2;
    check("reset_no_pulse", pulses, np);
    cmd(16'h0010, 1, 0, 4'b1111, 32'h0, 0, 0, 32'h1122_3344, 0);
    wait_done("post_reset_read");
    check("post_reset_latency", last_lat, 3);
    check("post_reset_data", avs.avs_readdata, 32'h1122_3344);
    check("total_completions", pulses, 9);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end
endmodule
